// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, one-hot state encodings and strobe bit positions
// Shared by the control sequencer and its output decode table.
package cpu_pkg;

  localparam int OPW = 3;

  localparam logic [2:0] OP_HLT  = 3'b000;
  localparam logic [2:0] OP_SKZ  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100;
  localparam logic [2:0] OP_LDA  = 3'b101;
  localparam logic [2:0] OP_STO  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  localparam int NST = 10;

  localparam logic [NST-1:0] ST_IDLE = 10'b00_0000_0001;
  localparam logic [NST-1:0] ST_S0   = 10'b00_0000_0010;
  localparam logic [NST-1:0] ST_S1   = 10'b00_0000_0100;
  localparam logic [NST-1:0] ST_S2   = 10'b00_0000_1000;
  localparam logic [NST-1:0] ST_S3   = 10'b00_0001_0000;
  localparam logic [NST-1:0] ST_S4   = 10'b00_0010_0000;
  localparam logic [NST-1:0] ST_S5   = 10'b00_0100_0000;
  localparam logic [NST-1:0] ST_S6   = 10'b00_1000_0000;
  localparam logic [NST-1:0] ST_S7   = 10'b01_0000_0000;
  localparam logic [NST-1:0] ST_HALT = 10'b10_0000_0000;

  localparam int STB_W        = 8;
  localparam int STB_INC_PC   = 0;
  localparam int STB_LOAD_PC  = 1;
  localparam int STB_LOAD_ACC = 2;
  localparam int STB_LOAD_IR  = 3;
  localparam int STB_RD       = 4;
  localparam int STB_WR       = 5;
  localparam int STB_DATACTL  = 6;
  localparam int STB_HALT     = 7;

  typedef logic [STB_W-1:0] strobe_t;

  // Opcodes that fetch an operand from memory into the accumulator via the ALU.
  function automatic logic is_acc_load(logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_op_decode.sv
// rtl/cpu_op_decode.sv - combinational strobe table for the sequencer
// Maps the state being entered plus opcode/zero onto the strobe bundle.
module cpu_op_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic [NST-1:0] state_nxt_i,
  input  logic [OPW-1:0] opcode_i,
  input  logic           zero_i,
  output strobe_t        strobe_o
);

  always_comb begin
    strobe_o = '0;
    case (state_nxt_i)
      ST_S0, ST_S1: begin
        strobe_o[STB_RD]      = 1'b1;
        strobe_o[STB_LOAD_IR] = 1'b1;
        strobe_o[STB_INC_PC]  = 1'b1;
      end
      ST_S4: begin
        if (is_acc_load(opcode_i)) begin
          strobe_o[STB_RD] = 1'b1;
        end else if (opcode_i == OP_JMP) begin
          strobe_o[STB_LOAD_PC] = 1'b1;
        end else if (opcode_i == OP_STO) begin
          strobe_o[STB_DATACTL] = 1'b1;
        end else if (opcode_i == OP_SKZ) begin
          strobe_o[STB_INC_PC] = zero_i;
        end
      end
      ST_S5: begin
        if (is_acc_load(opcode_i)) begin
          strobe_o[STB_RD]       = 1'b1;
          strobe_o[STB_LOAD_ACC] = 1'b1;
        end else if (opcode_i == OP_JMP) begin
          strobe_o[STB_LOAD_PC] = 1'b1;
        end else if (opcode_i == OP_STO) begin
          strobe_o[STB_DATACTL] = 1'b1;
          strobe_o[STB_WR]      = 1'b1;
        end else if (opcode_i == OP_SKZ) begin
          strobe_o[STB_INC_PC] = zero_i;
        end
      end
      ST_S6: begin
        strobe_o[STB_DATACTL] = (opcode_i == OP_STO);
      end
      ST_HALT: begin
        strobe_o[STB_HALT] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// rtl/cpu_ctrl_seq.sv - instruction-cycle control sequencer, registered Moore strobes
// Optional HALT_RESUME_EN: a rising fetch edge while halted restarts at S0.
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           fetch,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           inc_pc,
  output logic           load_pc,
  output logic           load_acc,
  output logic           load_ir,
  output logic           rd,
  output logic           wr,
  output logic           datactl_ena,
  output logic           halt
);

  logic [NST-1:0] state_q, state_d;
  strobe_t        strobe_q, strobe_d;
  logic           resume;

`ifdef HALT_RESUME_EN
  logic fetch_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_q <= 1'b0;
    end else begin
      fetch_q <= fetch;
    end
  end

  assign resume = fetch & ~fetch_q;
`else
  assign resume = 1'b0;
`endif

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = fetch ? ST_S0 : ST_IDLE;
      ST_S0:   state_d = ST_S1;
      ST_S1:   state_d = ST_S2;
      ST_S2:   state_d = ST_S3;
      ST_S3:   state_d = (opcode == OP_HLT) ? ST_HALT : ST_S4;
      ST_S4:   state_d = ST_S5;
      ST_S5:   state_d = ST_S6;
      ST_S6:   state_d = ST_S7;
      ST_S7:   state_d = ST_S0;
      ST_HALT: state_d = resume ? ST_S0 : ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the state being entered so they land with it.
  cpu_op_decode #(
    .OPW (OPW)
  ) u_decode (
    .state_nxt_i (state_d),
    .opcode_i    (opcode),
    .zero_i      (zero),
    .strobe_o    (strobe_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
    end
  end

  assign inc_pc      = strobe_q[STB_INC_PC];
  assign load_pc     = strobe_q[STB_LOAD_PC];
  assign load_acc    = strobe_q[STB_LOAD_ACC];
  assign load_ir     = strobe_q[STB_LOAD_IR];
  assign rd          = strobe_q[STB_RD];
  assign wr          = strobe_q[STB_WR];
  assign datactl_ena = strobe_q[STB_DATACTL];
  assign halt        = strobe_q[STB_HALT];

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb/tb_cpu_ctrl_seq.sv - vector table, corner sequences and random run vs phase model
// Honours HALT_RESUME_EN in both the halt sequence and the reference model.
module tb_cpu_ctrl_seq;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  // Observation byte: {halt, datactl_ena, wr, rd, load_ir, load_acc, load_pc, inc_pc}
  localparam logic [7:0] M_INC = 8'h01, M_LPC = 8'h02, M_ACC = 8'h04, M_IR  = 8'h08;
  localparam logic [7:0] M_RD  = 8'h10, M_WR  = 8'h20, M_DCT = 8'h40, M_HLT = 8'h80;
  localparam logic [7:0] FETCH_BYTE = 8'h19;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fetch = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt;
  logic [7:0] obs;

  cpu_ctrl_seq #(.OPW(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch       (fetch),
    .opcode      (opcode),
    .zero        (zero),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_acc    (load_acc),
    .load_ir     (load_ir),
    .rd          (rd),
    .wr          (wr),
    .datactl_ena (datactl_ena),
    .halt        (halt)
  );

  assign obs = {halt, datactl_ena, wr, rd, load_ir, load_acc, load_pc, inc_pc};

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: phase -1 = idle, 0..7 = instruction step, 8 = halted.
  int         ph = -1;
  bit         prev_f = 1'b0;
  logic [7:0] exp_m = 8'h00;

  typedef struct {
    logic       rst;
    logic       f;
    logic [2:0] op;
    logic       z;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(logic r, logic f, logic [2:0] op, logic z, logic [7:0] e);
    vec_t v;
    v.rst = r; v.f = f; v.op = op; v.z = z; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic void addi(logic f0, logic [2:0] op, logic z,
                               logic [7:0] e4, logic [7:0] e5, logic [7:0] e6);
    addv(1'b1, f0, op, z, FETCH_BYTE);
    addv(1'b1, 1'b0, op, z, FETCH_BYTE);
    addv(1'b1, 1'b0, op, z, 8'h00);
    addv(1'b1, 1'b0, op, z, 8'h00);
    addv(1'b1, 1'b0, op, z, e4);
    addv(1'b1, 1'b0, op, z, e5);
    addv(1'b1, 1'b0, op, z, e6);
    addv(1'b1, 1'b0, op, z, 8'h00);
  endfunction

  function automatic logic [7:0] ref_out(int p, logic [2:0] op, logic z);
    logic [7:0] o;
    bit alu;
    o = 8'h00;
    alu = (op >= 3'd2) && (op <= 3'd5);
    case (p)
      0, 1: o = M_RD | M_IR | M_INC;
      4: begin
        if (alu)            o = M_RD;
        else if (op == JMP) o = M_LPC;
        else if (op == STO) o = M_DCT;
        else if (op == SKZ) o = z ? M_INC : 8'h00;
      end
      5: begin
        if (alu)            o = M_RD | M_ACC;
        else if (op == JMP) o = M_LPC;
        else if (op == STO) o = M_DCT | M_WR;
        else if (op == SKZ) o = z ? M_INC : 8'h00;
      end
      6: o = (op == STO) ? M_DCT : 8'h00;
      8: o = M_HLT;
      default: o = 8'h00;
    endcase
    return o;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic step(string nm);
    int np;
    bit edge_up;
    @(posedge clk);
    if (!reset) begin
      ph = -1;
      prev_f = 1'b0;
      exp_m = 8'h00;
    end else begin
      edge_up = fetch && !prev_f;
      if (ph < 0)                          np = fetch ? 0 : -1;
      else if (ph == 8) begin
`ifdef HALT_RESUME_EN
        np = edge_up ? 0 : 8;
`else
        np = 8;
`endif
      end
      else if (ph == 3 && opcode == HLT)   np = 8;
      else                                 np = (ph + 1) % 8;
      ph = np;
      prev_f = fetch;
      exp_m = ref_out(ph, opcode, zero);
    end
    #1;
    chk(nm, obs, exp_m);
    chk("onehot_rd_wr", {7'd0, rd & wr}, 8'h00);
    chk("onehot_pc", {7'd0, load_pc & inc_pc}, 8'h00);
  endtask

  initial begin
    // Reset held with fetch high, then one instruction of each class.
    addv(1'b0, 1'b1, LDA, 1'b0, 8'h00);
    addv(1'b0, 1'b1, LDA, 1'b0, 8'h00);
    addv(1'b0, 1'b1, LDA, 1'b0, 8'h00);
    addi(1'b1, LDA, 1'b0, M_RD, M_RD | M_ACC, 8'h00);
    addi(1'b0, JMP, 1'b0, M_LPC, M_LPC, 8'h00);
    addi(1'b0, STO, 1'b0, M_DCT, M_DCT | M_WR, M_DCT);
    addi(1'b0, SKZ, 1'b1, M_INC, M_INC, 8'h00);
    addi(1'b0, SKZ, 1'b0, 8'h00, 8'h00, 8'h00);
    addi(1'b0, ADD, 1'b1, M_RD, M_RD | M_ACC, 8'h00);
    addv(1'b1, 1'b0, HLT, 1'b0, FETCH_BYTE);
    addv(1'b1, 1'b0, HLT, 1'b0, FETCH_BYTE);
    addv(1'b1, 1'b0, HLT, 1'b0, 8'h00);
    addv(1'b1, 1'b0, HLT, 1'b0, 8'h00);
    addv(1'b1, 1'b0, HLT, 1'b0, M_HLT);
    addv(1'b1, 1'b0, HLT, 1'b0, M_HLT);
    addv(1'b0, 1'b0, HLT, 1'b0, 8'h00);
    addv(1'b1, 1'b0, LDA, 1'b0, 8'h00);
    addv(1'b1, 1'b0, LDA, 1'b0, 8'h00);
    addv(1'b1, 1'b1, LDA, 1'b0, FETCH_BYTE);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      fetch = vecs[i].f;
      opcode = vecs[i].op;
      zero = vecs[i].z;
      step("model_vec");
      chk($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // Reset landing in the middle of a STO cycle.
    fetch = 1'b0;
    opcode = STO;
    for (int i = 0; i < 4; i++) step("mid_run");
    chk("sto_s4", obs, M_DCT);
    reset = 1'b0;
    step("mid_reset_model");
    chk("mid_reset", obs, 8'h00);
    reset = 1'b1;

    // Halt entry, hold and exit.
    fetch = 1'b1;
    opcode = HLT;
    step("halt_arm");
    chk("halt_arm", obs, FETCH_BYTE);
    for (int i = 0; i < 3; i++) step("halt_s");
    step("halt_entry_model");
    chk("halt_entry", obs, M_HLT);
`ifdef HALT_RESUME_EN
    fetch = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step("halt_hold_model");
      chk("halt_hold", obs, M_HLT);
    end
    fetch = 1'b1;
    step("resume_model");
    chk("resume", obs, FETCH_BYTE);
    fetch = 1'b0;
    opcode = HLT;
    for (int i = 0; i < 4; i++) step("rehalt_s");
    chk("rehalt", obs, M_HLT);
`else
    for (int i = 0; i < 20; i++) begin
      fetch = i[0];
      step("halt_hold_model");
      chk("halt_hold", obs, M_HLT);
    end
`endif
    reset = 1'b0;
    step("halt_reset_model");
    chk("halt_reset", obs, 8'h00);
    reset = 1'b1;
    fetch = 1'b0;
    step("idle_model");
    chk("idle_after_reset", obs, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 39) != 0);
      fetch = ($urandom_range(0, 3) == 0);
      opcode = 3'($urandom_range(0, 7));
      zero = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
